// File: rtl/equiv_stim_sequencer.sv
// Stimulus and comparison sequencer for the dual-instance equivalence harness.
// Drives one 64-bit LFSR vector per cycle to both instances and scores their outputs LAT cycles later.
module equiv_stim_sequencer #(
    parameter int unsigned NUM_VECTORS = 1024,
    parameter int unsigned WARMUP      = 4,
    parameter int unsigned LAT         = 1,
    parameter logic [63:0] SEED        = 64'h1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] seed_in,
    input  logic        stop_on_fail,
    input  logic [90:0] y_1,
    input  logic [90:0] y_2,
    output logic [10:0] wire0,
    output logic [12:0] wire1,
    output logic [19:0] wire2,
    output logic [19:0] wire3,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] mismatch_cnt,
    output logic        first_fail_valid,
    output logic [31:0] first_fail_idx,
    output logic [31:0] vec_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Galois taps for x^64+x^63+x^61+x^60+1, right-shifting form
    localparam logic [63:0] TAPS       = 64'hD800_0000_0000_0000;
    localparam logic [31:0] WARM_LAST  = (WARMUP == 0) ? 32'd0 : 32'(WARMUP - 1);
    localparam logic [31:0] RUN_LAST   = 32'(NUM_VECTORS - 1);
    localparam logic [31:0] DRAIN_LAST = 32'(LAT - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] cnt;
    logic [63:0] lfsr;
    logic [63:0] lfsr_step;
    logic        stop_run;
    logic        pipe_valid [LAT];
    logic [31:0] pipe_idx   [LAT];

    logic start_ok;
    logic advance;
    logic cmp_valid;
    logic miss;
    logic stop_now;

    always_comb begin
        start_ok  = (state == S_IDLE) && start;
        advance   = (state == S_WARMUP) || (state == S_RUN);
        busy      = (state == S_WARMUP) || (state == S_RUN) || (state == S_DRAIN);
        // Compares are gated by state so entries abandoned by an early stop never score
        cmp_valid = ((state == S_RUN) || (state == S_DRAIN)) && pipe_valid[LAT-1];
        miss      = cmp_valid && (y_1 != y_2);
        stop_now  = miss && stop_run;
        lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (WARMUP == 0) ? S_RUN : S_WARMUP;
                end
            end
            S_WARMUP: begin
                if (cnt == WARM_LAST) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (stop_now) begin
                    state_next = S_DONE;
                end else if (cnt == RUN_LAST) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (stop_now || (cnt == DRAIN_LAST)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // One counter serves as warmup count, vector index and drain count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start_ok || (state_next != state)) begin
            cnt <= '0;
        end else if (busy) begin
            cnt <= cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr     <= SEED;
            stop_run <= 1'b0;
        end else if (start_ok) begin
            lfsr     <= (seed_in == '0) ? SEED : seed_in;
            stop_run <= stop_on_fail;
        end else if (advance) begin
            lfsr <= lfsr_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_idx[i]   <= '0;
            end
        end else if (start_ok) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                pipe_valid[i] <= 1'b0;
            end
        end else begin
            pipe_valid[0] <= (state == S_RUN);
            pipe_idx[0]   <= cnt;
            for (int unsigned i = 1; i < LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_idx[i]   <= pipe_idx[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wire0   <= SEED[10:0];
            wire1   <= SEED[23:11];
            wire2   <= SEED[43:24];
            wire3   <= SEED[63:44];
            vec_idx <= '0;
        end else if (start_ok) begin
            vec_idx <= '0;
        end else if (advance) begin
            wire0 <= lfsr[10:0];
            wire1 <= lfsr[23:11];
            wire2 <= lfsr[43:24];
            wire3 <= lfsr[63:44];
            if (state == S_RUN) begin
                vec_idx <= cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else if (start_ok) begin
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else if (miss) begin
            if (mismatch_cnt != '1) begin
                mismatch_cnt <= mismatch_cnt + 16'd1;
            end
            if (!first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_idx   <= pipe_idx[LAT-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            if (start_ok) begin
                pass <= 1'b0;
            end else if (state == S_DONE) begin
                pass <= (mismatch_cnt == '0);
            end
        end
    end

endmodule

// File: tb/tb_equiv_stim_sequencer.sv
// Bench for equiv_stim_sequencer: table-driven and random runs against a vector/score model,
// a mid-run reset abort, and a long saturating run on a second instance.
`timescale 1ns/1ps
module tb_equiv_stim_sequencer;

    localparam int unsigned NV  = 16;
    localparam int unsigned WU  = 2;
    localparam int unsigned LT  = 1;
    localparam int unsigned NV2 = 70000;
    localparam int unsigned LT2 = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start, stop_on_fail, busy, done, pass, first_fail_valid;
    logic [63:0] seed_in;
    logic [90:0] y_1, y_2;
    logic [10:0] wire0;
    logic [12:0] wire1;
    logic [19:0] wire2, wire3;
    logic [15:0] mismatch_cnt;
    logic [31:0] first_fail_idx, vec_idx;

    logic        start_b, stop_b, busy_b, done_b, pass_b, ffv_b;
    logic [63:0] seed_b;
    logic [90:0] y_1b, y_2b;
    logic [10:0] wire0_b;
    logic [12:0] wire1_b;
    logic [19:0] wire2_b, wire3_b;
    logic [15:0] cnt_b;
    logic [31:0] ffidx_b, vec_idx_b;

    equiv_stim_sequencer #(.NUM_VECTORS(NV), .WARMUP(WU), .LAT(LT), .SEED(64'h1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed_in(seed_in), .stop_on_fail(stop_on_fail),
        .y_1(y_1), .y_2(y_2), .wire0(wire0), .wire1(wire1), .wire2(wire2), .wire3(wire3),
        .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
        .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx), .vec_idx(vec_idx)
    );

    equiv_stim_sequencer #(.NUM_VECTORS(NV2), .WARMUP(0), .LAT(LT2), .SEED(64'h1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start_b), .seed_in(seed_b), .stop_on_fail(stop_b),
        .y_1(y_1b), .y_2(y_2b), .wire0(wire0_b), .wire1(wire1_b), .wire2(wire2_b), .wire3(wire3_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .mismatch_cnt(cnt_b),
        .first_fail_valid(ffv_b), .first_fail_idx(ffidx_b), .vec_idx(vec_idx_b)
    );

    typedef struct {
        logic [63:0] seed;
        logic        stop;
        logic [15:0] mask;
        int unsigned exp_cnt;
        logic        exp_ffv;
        int unsigned exp_first;
        int unsigned done_k;
    } vec_t;

    vec_t vecs [8];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] lfsr_adv(input logic [63:0] s);
        return s[0] ? ((s >> 1) ^ 64'hD800_0000_0000_0000) : (s >> 1);
    endfunction

    function automatic logic [90:0] rand_y();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[90:0];
    endfunction

    // One full run; k counts edges after the accepted start edge.
    task automatic do_run(input string tag, input logic [63:0] seed, input logic stop,
                          input logic [15:0] mask, input int unsigned exp_cnt, input logic exp_ffv,
                          input int unsigned exp_first, input int unsigned k_done);
        logic [63:0] m;
        logic [90:0] y;
        int unsigned k_stop, k_vec;
        int          ci;
        m      = (seed == 64'd0) ? 64'h1 : seed;
        k_stop = (stop && exp_ffv) ? 1 + WU + exp_first + LT : 32'hFFFF_FFFF;
        k_vec  = (WU + NV < k_stop) ? WU + NV : k_stop;
        @(negedge clk);
        start = 1'b1; seed_in = seed; stop_on_fail = stop;
        y = rand_y(); y_1 = y; y_2 = y;
        @(posedge clk); #1;
        chk($sformatf("%s busy_k0", tag), {63'd0, busy}, 64'd1);
        for (int unsigned k = 1; k <= k_done + 2; k++) begin
            @(negedge clk);
            start        = (k <= k_done) ? 1'($urandom_range(1)) : 1'b0;
            stop_on_fail = 1'($urandom_range(1));
            seed_in      = {$urandom(), $urandom()};
            ci = int'(k) - 1 - int'(WU) - int'(LT);
            y = rand_y(); y_1 = y; y_2 = y;
            if (ci >= 0 && ci < int'(NV)) begin
                if (mask[ci[3:0]]) y_2 = y ^ (91'd1 << $urandom_range(90));
            end
            @(posedge clk); #1;
            if (k <= k_vec) begin
                chk($sformatf("%s wire_k%0d", tag, k), {wire3, wire2, wire1, wire0}, m);
                m = lfsr_adv(m);
                if (k > WU) chk($sformatf("%s vec_idx_k%0d", tag, k), {32'd0, vec_idx}, 64'(k - 1 - WU));
            end
            chk($sformatf("%s done_k%0d", tag, k), {63'd0, done}, {63'd0, k == k_done});
            chk($sformatf("%s busy_k%0d", tag, k), {63'd0, busy}, {63'd0, (k + 1) < k_done});
            if (k == k_done || k == k_done + 2) begin
                chk($sformatf("%s mismatch_cnt", tag), {48'd0, mismatch_cnt}, 64'(exp_cnt));
                chk($sformatf("%s first_fail_valid", tag), {63'd0, first_fail_valid}, {63'd0, exp_ffv});
                if (exp_ffv) chk($sformatf("%s first_fail_idx", tag), {32'd0, first_fail_idx}, 64'(exp_first));
                chk($sformatf("%s pass", tag), {63'd0, pass}, {63'd0, exp_cnt == 0});
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int unsigned k_sat;
        logic [15:0] rm;
        logic        rs;
        int unsigned rc, rf;
        logic [90:0] y;

        vecs[0] = '{64'h1, 1'b0, 16'h0000, 0, 1'b0, 0, 20};
        vecs[1] = '{64'h1, 1'b0, 16'h0220, 2, 1'b1, 5, 20};
        vecs[2] = '{64'h1, 1'b1, 16'h0220, 1, 1'b1, 5, 10};
        vecs[3] = '{64'h0, 1'b0, 16'h0000, 0, 1'b0, 0, 20};
        vecs[4] = '{64'h1, 1'b0, 16'h8000, 1, 1'b1, 15, 20};
        vecs[5] = '{64'hDEAD_BEEF_0123_4567, 1'b1, 16'h0001, 1, 1'b1, 0, 5};
        vecs[6] = '{64'h1, 1'b1, 16'h8000, 1, 1'b1, 15, 20};
        vecs[7] = '{64'h5A5A_0000_FFFF_1234, 1'b0, 16'hFFFF, 16, 1'b1, 0, 20};

        start = 1'b0; seed_in = '0; stop_on_fail = 1'b0; y_1 = '0; y_2 = '0;
        start_b = 1'b0; seed_b = '0; stop_b = 1'b0;
        y_1b = rand_y(); y_2b = ~y_1b;

        #12;
        chk("reset wire", {wire3, wire2, wire1, wire0}, 64'h1);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset pass", {63'd0, pass}, 64'd0);
        chk("reset mismatch_cnt", {48'd0, mismatch_cnt}, 64'd0);
        chk("reset ffv", {63'd0, first_fail_valid}, 64'd0);
        chk("reset vec_idx", {32'd0, vec_idx}, 64'd0);
        chk("reset sat wire", {wire3_b, wire2_b, wire1_b, wire0_b}, 64'h1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int unsigned t = 0; t < 8; t++) begin
            do_run($sformatf("tab%0d", t), vecs[t].seed, vecs[t].stop, vecs[t].mask,
                   vecs[t].exp_cnt, vecs[t].exp_ffv, vecs[t].exp_first, vecs[t].done_k);
        end

        for (int unsigned r = 0; r < 12; r++) begin
            rm = 16'($urandom() & $urandom() & $urandom());
            rs = 1'($urandom_range(1));
            rf = 0;
            for (int unsigned b = 16; b > 0; b--) if (rm[b-1]) rf = b - 1;
            rc = (rs && rm != 0) ? 1 : $countones(rm);
            do_run($sformatf("rnd%0d", r), {$urandom(), $urandom()}, rs, rm, rc, rm != 0, rf,
                   (rs && rm != 0) ? 2 + WU + rf + LT : 1 + WU + NV + LT);
        end

        // Abort mid-RUN with start held high, then restart.
        @(negedge clk);
        start = 1'b1; seed_in = 64'h1; stop_on_fail = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            y = rand_y(); y_1 = y; y_2 = (k == 1 + int'(WU) + 1 + int'(LT)) ? ~y : y;
            @(posedge clk);
        end
        #1;
        chk("abort pre cnt", {48'd0, mismatch_cnt}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort wire", {wire3, wire2, wire1, wire0}, 64'h1);
        chk("abort busy", {63'd0, busy}, 64'd0);
        chk("abort mismatch_cnt", {48'd0, mismatch_cnt}, 64'd0);
        chk("abort ffv", {63'd0, first_fail_valid}, 64'd0);
        chk("abort ffidx", {32'd0, first_fail_idx}, 64'd0);
        chk("abort vec_idx", {32'd0, vec_idx}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abort no done", {63'd0, done}, 64'd0);
        end
        @(negedge clk);
        start = 1'b0; rst_n = 1'b1;
        do_run("restart", 64'h1, 1'b0, 16'h0000, 0, 1'b0, 0, 20);

        // Long run with permanently differing outputs on the second instance.
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk); #1;
        k_sat = 0;
        for (int unsigned k = 1; k <= NV2 + LT2 + 20; k++) begin
            @(negedge clk);
            start_b = 1'b0;
            @(posedge clk); #1;
            if (k == 1) begin
                chk("sat first wire", {wire3_b, wire2_b, wire1_b, wire0_b}, 64'h1);
                chk("sat first vec_idx", {32'd0, vec_idx_b}, 64'd0);
                chk("sat busy", {63'd0, busy_b}, 64'd1);
            end
            if (k == LT2) chk("sat cnt before first compare", {48'd0, cnt_b}, 64'd0);
            if (k == LT2 + 1) chk("sat cnt at first compare", {48'd0, cnt_b}, 64'd1);
            if (done_b) begin
                k_sat = k;
                break;
            end
        end
        chk("sat done cycle", 64'(k_sat), 64'(1 + NV2 + LT2));
        chk("sat mismatch_cnt", {48'd0, cnt_b}, 64'hFFFF);
        chk("sat ffv", {63'd0, ffv_b}, 64'd1);
        chk("sat ffidx", {32'd0, ffidx_b}, 64'd0);
        chk("sat pass", {63'd0, pass_b}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
